// File: rtl/mem_map_pkg.sv
// Shared definitions for the 16-bit memory map: region codes, bus FSM states
// and default wait-state counts used by the controller and other map consumers.
package mem_map_pkg;

  localparam logic [2:0] REG_ROM      = 3'd0;
  localparam logic [2:0] REG_RAM      = 3'd1;
  localparam logic [2:0] REG_PERIPH   = 3'd2;
  localparam logic [2:0] REG_EXT      = 3'd3;
  localparam logic [2:0] REG_UNMAPPED = 3'd4;
  localparam logic [2:0] REG_FLASH    = 3'd7;

  localparam int unsigned WS_ROM_DEF    = 32'd2;
  localparam int unsigned WS_RAM_DEF    = 32'd0;
  localparam int unsigned WS_PERIPH_DEF = 32'd1;
  localparam int unsigned WS_EXT_DEF    = 32'd3;
  localparam int unsigned WS_FLASH_DEF  = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  function automatic logic region_is_mapped(input logic [2:0] region);
    return (region != REG_UNMAPPED);
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Address-to-region decoder for the 16-bit memory map; looks at the top
// nibble only, everything not listed falls into the unmapped region.
module mem_region_decode
  import mem_map_pkg::*;
(
  input  logic [15:0] addr_i,
  output logic [2:0]  region_o
);

  // Top-nibble region lookup
  always_comb begin
    region_o = REG_UNMAPPED;
    casez (addr_i)
      16'h0???: region_o = REG_ROM;
      16'h1???: region_o = REG_RAM;
      16'h2???: region_o = REG_PERIPH;
      16'h3???: region_o = REG_EXT;
      16'hF???: region_o = REG_FLASH;
      default:  region_o = REG_UNMAPPED;
    endcase
  end

endmodule

// File: rtl/mem_region_bus_ctrl.sv
// Two-master round-robin bus controller: arbitrates, decodes the winning
// address, inserts per-region wait states and returns done/err to the winner.
module mem_region_bus_ctrl
  import mem_map_pkg::*;
#(
  parameter int unsigned WS_ROM    = WS_ROM_DEF,
  parameter int unsigned WS_RAM    = WS_RAM_DEF,
  parameter int unsigned WS_PERIPH = WS_PERIPH_DEF,
  parameter int unsigned WS_EXT    = WS_EXT_DEF,
  parameter int unsigned WS_FLASH  = WS_FLASH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [15:0] m0_addr,
  input  logic        m0_we,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [15:0] m1_addr,
  input  logic        m1_we,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        m1_err,
  output logic        bus_valid,
  output logic [15:0] bus_addr,
  output logic        bus_we,
  output logic [2:0]  bus_region
);

  function automatic logic [2:0] ws_of(input logic [2:0] region);
    logic [2:0] ws;
    case (region)
      REG_ROM:    ws = 3'(WS_ROM);
      REG_RAM:    ws = 3'(WS_RAM);
      REG_PERIPH: ws = 3'(WS_PERIPH);
      REG_EXT:    ws = 3'(WS_EXT);
      REG_FLASH:  ws = 3'(WS_FLASH);
      default:    ws = 3'd0;
    endcase
    return ws;
  endfunction

  bus_state_e  state_q;
  logic [2:0]  cnt_q;
  logic        ptr_q;
  logic        win_q;
  logic        m0_gnt_q, m0_done_q, m0_err_q;
  logic        m1_gnt_q, m1_done_q, m1_err_q;
  logic        bus_valid_q;
  logic [15:0] bus_addr_q;
  logic        bus_we_q;
  logic [2:0]  bus_region_q;

  logic        any_req_d;
  logic        win_d;
  logic [15:0] sel_addr_d;
  logic        sel_we_d;
  logic [2:0]  sel_region_d;

  // Round-robin choice: a sole requester wins, a tie goes to the pointer master
  always_comb begin
    any_req_d = m0_req | m1_req;
    if (m0_req && m1_req) begin
      win_d = ptr_q;
    end else if (m1_req) begin
      win_d = 1'b1;
    end else begin
      win_d = 1'b0;
    end
    if (win_d) begin
      sel_addr_d = m1_addr;
      sel_we_d   = m1_we;
    end else begin
      sel_addr_d = m0_addr;
      sel_we_d   = m0_we;
    end
  end

  mem_region_decode u_decode (
    .addr_i   (sel_addr_d),
    .region_o (sel_region_d)
  );

  // Bus FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      ptr_q        <= 1'b0;
      win_q        <= 1'b0;
      m0_gnt_q     <= 1'b0;
      m0_done_q    <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      m1_done_q    <= 1'b0;
      m1_err_q     <= 1'b0;
      bus_valid_q  <= 1'b0;
      bus_addr_q   <= 16'h0000;
      bus_we_q     <= 1'b0;
      bus_region_q <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            win_q        <= win_d;
            bus_addr_q   <= sel_addr_d;
            bus_we_q     <= sel_we_d;
            bus_region_q <= sel_region_d;
            m0_gnt_q     <= ~win_d;
            m1_gnt_q     <= win_d;
            if (region_is_mapped(sel_region_d)) begin
              cnt_q       <= ws_of(sel_region_d);
              bus_valid_q <= 1'b1;
              state_q     <= ST_ACCESS;
            end else begin
              // Unmapped accesses never reach the slave; answer immediately
              m0_err_q <= ~win_d;
              m1_err_q <= win_d;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_q == 3'd0) begin
            bus_valid_q <= 1'b0;
            m0_done_q   <= ~win_q;
            m1_done_q   <= win_q;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_RESP: begin
          m0_gnt_q  <= 1'b0;
          m1_gnt_q  <= 1'b0;
          m0_done_q <= 1'b0;
          m1_done_q <= 1'b0;
          m0_err_q  <= 1'b0;
          m1_err_q  <= 1'b0;
          ptr_q     <= ~win_q;
          state_q   <= ST_IDLE;
        end
        default: begin
          m0_gnt_q    <= 1'b0;
          m1_gnt_q    <= 1'b0;
          m0_done_q   <= 1'b0;
          m1_done_q   <= 1'b0;
          m0_err_q    <= 1'b0;
          m1_err_q    <= 1'b0;
          bus_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_gnt     = m0_gnt_q;
  assign m0_done    = m0_done_q;
  assign m0_err     = m0_err_q;
  assign m1_gnt     = m1_gnt_q;
  assign m1_done    = m1_done_q;
  assign m1_err     = m1_err_q;
  assign bus_valid  = bus_valid_q;
  assign bus_addr   = bus_addr_q;
  assign bus_we     = bus_we_q;
  assign bus_region = bus_region_q;

endmodule

// File: tb/tb_mem_region_bus_ctrl.sv
// Bench for mem_region_bus_ctrl: a transaction-schedule reference model predicts
// every output each cycle; scenario tasks add directed latency/ordering checks.
module tb_mem_region_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [15:0] m0_addr = 16'h0000, m1_addr = 16'h0000;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic        bus_valid, bus_we;
  logic [15:0] bus_addr;
  logic [2:0]  bus_region;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_region_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_we(bus_we), .bus_region(bus_region)
  );

  wire [26:0] dut_vec = {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err,
                         bus_valid, bus_we, bus_region, bus_addr};

  // Reference model: one pending transaction described by its start edge and timing
  int          cyc = 0;
  bit          busy = 1'b0;
  int          start = 0;
  bit          mw = 1'b0;
  bit          mptr = 1'b0;
  bit          munm = 1'b0;
  int          mws = 0;
  logic [15:0] maddr = 16'h0000;
  logic        mwe = 1'b0;
  logic [2:0]  mreg = 3'd0;

  function automatic logic [2:0] ref_region(input logic [15:0] a);
    int nib;
    nib = int'(a) / 4096;
    if (nib <= 3) return 3'(nib);
    else if (nib == 15) return 3'd7;
    else return 3'd4;
  endfunction

  function automatic int ref_ws(input logic [2:0] r);
    case (r)
      3'd0: return 2;
      3'd1: return 0;
      3'd2: return 1;
      3'd3: return 3;
      3'd7: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    int off, resp;
    cyc++;
    if (!rst_n) begin
      busy = 1'b0; mptr = 1'b0; maddr = 16'h0000; mwe = 1'b0; mreg = 3'd0;
    end else if (busy) begin
      off  = cyc - start + 1;
      resp = munm ? 1 : mws + 2;
      if (off == resp + 1) begin
        busy = 1'b0;
        mptr = ~mw;
      end
    end else if (m0_req || m1_req) begin
      mw    = (m0_req && m1_req) ? mptr : m1_req;
      maddr = mw ? m1_addr : m0_addr;
      mwe   = mw ? m1_we : m0_we;
      mreg  = ref_region(maddr);
      munm  = (mreg == 3'd4);
      mws   = ref_ws(mreg);
      busy  = 1'b1;
      start = cyc;
    end
  endtask

  function automatic logic [26:0] exp_vec();
    int off;
    bit g, v, d, e;
    off = cyc - start + 1;
    g = busy;
    v = busy && !munm && off <= mws + 1;
    d = busy && !munm && off == mws + 2;
    e = busy && munm;
    return {g && !mw, d && !mw, e && !mw, g && mw, d && mw, e && mw, v, mwe, mreg, maddr};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 16'h1000; m1_addr = 16'h2000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec !== 27'd0) begin
        errors++;
        $display("FAIL reset cycle %0d outputs=%h required=0", i, dut_vec);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ram();
    m0_req = 1'b1; m0_addr = 16'h1FFF; m0_we = 1'b1;
    step();
    checks++;
    if ({m0_gnt, bus_valid, bus_region, m1_gnt} !== {1'b1, 1'b1, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL ram_grant gnt/valid/region/m1gnt=%b required=1100 1 0", {m0_gnt, bus_valid, bus_region, m1_gnt});
    end
    step();
    checks++;
    if ({m0_done, m0_err, bus_valid, m1_gnt, m1_done, m1_err} !== 6'b100000) begin
      errors++;
      $display("FAIL ram_done done/err/valid/m1=%b required=100000", {m0_done, m0_err, bus_valid, m1_gnt, m1_done, m1_err});
    end
    m0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL ram_tail cycle %0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_flash();
    int vcnt, done_at;
    vcnt = 0; done_at = -1;
    m1_req = 1'b1; m1_addr = 16'hF800; m1_we = 1'b0;
    for (int i = 1; i <= 20 && done_at < 0; i++) begin
      step();
      if (bus_valid) vcnt++;
      if (m1_done) done_at = i;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL flash cycle %0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    m1_req = 1'b0;
    checks++;
    if (vcnt != 5 || done_at != 6 || bus_region !== 3'd7) begin
      errors++;
      $display("FAIL flash_latency valid_cycles=%0d done_at=%0d region=%0d required 5 6 7", vcnt, done_at, bus_region);
    end
    step(); step();
  endtask

  task automatic test_unmapped();
    m0_req = 1'b1; m0_addr = 16'h5000;
    step();
    checks++;
    if ({m0_err, m0_done, bus_valid, m0_gnt, bus_region} !== {4'b1001, 3'd4}) begin
      errors++;
      $display("FAIL unmapped err/done/valid/gnt/region=%b required=1001100", {m0_err, m0_done, bus_valid, m0_gnt, bus_region});
    end
    m0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL unmapped_tail cycle %0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_alternation();
    int gidx;
    bit prev;
    bit ord[4];
    int vc[4];
    gidx = -1; prev = 1'b0;
    for (int i = 0; i < 4; i++) begin ord[i] = 1'b0; vc[i] = 0; end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    m0_req = 1'b1; m0_addr = 16'h0123; m1_req = 1'b1; m1_addr = 16'h2500;
    for (int i = 0; i < 12; i++) begin
      step();
      if ((m0_gnt || m1_gnt) && !prev) begin
        gidx++;
        if (gidx < 4) ord[gidx] = m1_gnt;
      end
      prev = m0_gnt || m1_gnt;
      if (bus_valid && gidx >= 0 && gidx < 4) vc[gidx]++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL alternate cycle %0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    checks++;
    if (gidx < 2 || ord[0] != 1'b0 || ord[1] != 1'b1 || ord[2] != 1'b0 || vc[0] != 3 || vc[1] != 2) begin
      errors++;
      $display("FAIL alternate_order grants=%0d order=%b%b%b valid=%0d,%0d required >=3 010 3,2",
               gidx + 1, ord[0], ord[1], ord[2], vc[0], vc[1]);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_reset_mid();
    m0_req = 1'b1; m0_addr = 16'h3000;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    checks++;
    if (dut_vec !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid outputs=%h required=0", dut_vec);
    end
    rst_n = 1'b1; m1_req = 1'b1; m1_addr = 16'h1000;
    step();
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_winner gnt=%b required=10", {m0_gnt, m1_gnt});
    end
    m0_req = 1'b0; m1_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_tail cycle %0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_req_change();
    m0_req = 1'b1; m0_addr = 16'h2100;
    step();
    m0_req = 1'b0; m0_addr = 16'h5000;
    step(); step();
    checks++;
    if ({m0_done, m0_err, bus_addr, bus_region} !== {2'b10, 16'h2100, 3'd2}) begin
      errors++;
      $display("FAIL req_change done/err=%b addr=%h region=%0d required 10 2100 2", {m0_done, m0_err}, bus_addr, bus_region);
    end
    step(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      m0_req  = ($urandom_range(0, 2) != 0);
      m1_req  = ($urandom_range(0, 2) != 0);
      m0_addr = 16'($urandom);
      m1_addr = 16'($urandom);
      m0_we   = 1'($urandom);
      m1_we   = 1'($urandom);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    rst_n = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_flash();
    test_unmapped();
    test_alternation();
    test_reset_mid();
    test_req_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
